// File: rtl/carry_select_subtractor_pipe_pkg.sv
// Shared constants and flag helpers for the pipelined carry-select subtractor.
// The stage-1 payload type depends on WIDTH/SPLIT, so it is declared inside the top.
package sub_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_SPLIT = 16;

  // Two's-complement overflow of a - b: operand signs differ and the result sign leaves the minuend's.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
    return (a_msb != b_msb) && (d_msb != a_msb);
  endfunction

  // Unsigned borrow out of the MSB, recovered from the operand and result sign bits alone.
  function automatic logic unsigned_borrow(input logic a_msb, input logic b_msb, input logic d_msb);
    return (!a_msb && b_msb) || ((a_msb == b_msb) && d_msb);
  endfunction

endpackage

// File: rtl/carry_select_subtractor_pipe_block.sv
// Carry-select adder slice: produces both the carry-in 0 and carry-in 1 sums, each with its carry-out.
module carry_select_block #(
  parameter int W = 16
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W:0]   sum_c0,
  output logic [W:0]   sum_c1
);

  assign sum_c0 = {1'b0, x} + {1'b0, y};
  assign sum_c1 = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, 1'b1};

endmodule

// File: rtl/carry_select_subtractor_pipe.sv
// Two-stage pipelined subtractor a - b = a + ~b + 1, low half resolved in stage 1,
// high half chosen in stage 2 from precomputed carry-select candidates. Valid/ready on both sides.
module carry_select_subtractor_pipe
  import sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SPLIT = DEF_SPLIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow
);

  localparam int HW = WIDTH - SPLIT;

  typedef struct packed {
    logic [HW-1:0]    hi0;
    logic [HW-1:0]    hi1;
    logic [SPLIT-1:0] lo;
    logic             c;
    logic             a_msb;
    logic             b_msb;
  } s1_t;

  logic [WIDTH-1:0] b_inv_s;
  logic [SPLIT:0]   lo_sum_s;
  logic [HW:0]      hi_c0_s;
  logic [HW:0]      hi_c1_s;
  logic             unused_carry_s;
  s1_t              s1_next_s;
  s1_t              s1_r;
  logic             s1_valid_r;
  logic             s2_valid_r;
  logic             s1_adv_s;
  logic             s2_adv_s;
  logic [HW-1:0]    hi_sel_s;
  logic [WIDTH-1:0] diff_next_s;

  assign b_inv_s  = ~b;
  assign lo_sum_s = {1'b0, a[SPLIT-1:0]} + {1'b0, b_inv_s[SPLIT-1:0]} + {{SPLIT{1'b0}}, 1'b1};

  carry_select_block #(.W(HW)) u_hi (
    .x      (a[WIDTH-1:SPLIT]),
    .y      (b_inv_s[WIDTH-1:SPLIT]),
    .sum_c0 (hi_c0_s),
    .sum_c1 (hi_c1_s)
  );

  // Borrow comes from the sign bits, so the high-half carry-outs are not needed.
  assign unused_carry_s = hi_c0_s[HW] ^ hi_c1_s[HW];

  assign s2_adv_s  = !s2_valid_r || out_ready;
  assign s1_adv_s  = !s1_valid_r || s2_adv_s;
  assign in_ready  = s1_adv_s && !rst;
  assign out_valid = s2_valid_r;

  // Stage-1 payload assembly from the incoming operands.
  always_comb begin
    s1_next_s       = '0;
    s1_next_s.hi0   = hi_c0_s[HW-1:0];
    s1_next_s.hi1   = hi_c1_s[HW-1:0];
    s1_next_s.lo    = lo_sum_s[SPLIT-1:0];
    s1_next_s.c     = lo_sum_s[SPLIT];
    s1_next_s.a_msb = a[WIDTH-1];
    s1_next_s.b_msb = b[WIDTH-1];
  end

  // Stage-2 carry select of the high half.
  always_comb begin
    hi_sel_s = '0;
    if (s1_r.c) begin
      hi_sel_s = s1_r.hi1;
    end else begin
      hi_sel_s = s1_r.hi0;
    end
    diff_next_s = {hi_sel_s, s1_r.lo};
  end

  // Stage 1 register: captures operands on accept, holds while stage 2 is blocked.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_r       <= '0;
    end else if (s1_adv_s) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_r <= s1_next_s;
      end
    end
  end

  // Stage 2 register: result outputs, frozen while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_r <= 1'b0;
      diff       <= '0;
      borrow     <= 1'b0;
      overflow   <= 1'b0;
    end else if (s2_adv_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        diff     <= diff_next_s;
        borrow   <= unsigned_borrow(s1_r.a_msb, s1_r.b_msb, diff_next_s[WIDTH-1]);
        overflow <= signed_ovf(s1_r.a_msb, s1_r.b_msb, diff_next_s[WIDTH-1]);
      end
    end
  end

endmodule
